// File: rtl/coeff_ram_loader.sv
// coeff_ram_loader: streams signed coefficients into the filter's 4x10 coefficient RAMs and zero-fills unused slots.
// Define COEFF_SYM_EN to accept only the first half of a symmetric set and mirror the rest from an internal buffer.
module coeff_ram_loader #(
    parameter int P_MAX_COEFF = 40,
    parameter int P_RAM_DEPTH = 10,
    parameter int P_DW        = 16
) (
    input  logic            iClk_12M,
    input  logic            iRst,
    input  logic            iLoadStart,
    input  logic [5:0]      iNumTaps,
    input  logic            iCoeffValid,
    input  logic [P_DW-1:0] iCoeffData,
    output logic            oCoeffReady,
    output logic            oCoeffiUpdateFlag,
    output logic            oCsnRam,
    output logic            oWrnRam,
    output logic [3:0]      oAddrRam,
    output logic [P_DW-1:0] oWrDtRam,
    output logic [5:0]      oNumOfCoeff,
    output logic            oBusy,
    output logic            oLoadDone,
    output logic            oErr
);
    localparam logic [5:0] LP_MAX  = 6'(P_MAX_COEFF);
    localparam logic [3:0] LP_WRAP = 4'(P_RAM_DEPTH - 1);

`ifdef COEFF_SYM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIRROR, S_ZFILL, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ZFILL, S_DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [5:0]      n_q, n_d, k_q, k_d;
    logic [3:0]      w_q, w_d;
    logic            ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            csn_q, csn_d;
    logic [3:0]      addr_q, addr_d;
    logic [P_DW-1:0] wdat_q, wdat_d;
    logic [5:0]      idx_q, idx_d;
    logic            wr;
    logic [P_DW-1:0] wr_data;
    logic [5:0]      load_last;
    state_t          after_data;

`ifdef COEFF_SYM_EN
    logic [P_DW-1:0] coef_buf_q [P_MAX_COEFF/2];
    logic [5:0]      half;
    logic [4:0]      mirror_idx;
    assign half       = (n_q >> 1) + {5'd0, n_q[0]};
    assign mirror_idx = 5'(n_q - 6'd1 - k_q);
    assign load_last  = half - 6'd1;
`else
    assign load_last  = n_q - 6'd1;
`endif
    // a full 40-tap set leaves nothing to zero-fill
    assign after_data = (n_q == LP_MAX) ? S_DONE : S_ZFILL;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        w_d     = w_q;
        err_d   = 1'b0;
        wr      = 1'b0;
        wr_data = '0;
        case (state_q)
            S_IDLE: if (iLoadStart) begin
                if (iNumTaps != 6'd0 && iNumTaps <= LP_MAX) begin
                    state_d = S_LOAD;
                    n_d     = iNumTaps;
                    k_d     = '0;
                    w_d     = '0;
                end else err_d = 1'b1;
            end
            S_LOAD: if (iCoeffValid && ready_q) begin
                wr      = 1'b1;
                wr_data = iCoeffData;
`ifdef COEFF_SYM_EN
                if (k_q == load_last) state_d = (half == n_q) ? after_data : S_MIRROR;
`else
                if (k_q == load_last) state_d = after_data;
`endif
            end
`ifdef COEFF_SYM_EN
            S_MIRROR: begin
                wr      = 1'b1;
                wr_data = coef_buf_q[mirror_idx];
                if (k_q == n_q - 6'd1) state_d = after_data;
            end
`endif
            S_ZFILL: begin
                wr = 1'b1;
                if (k_q == LP_MAX - 6'd1) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wr) begin
            k_d = k_q + 6'd1;
            w_d = (w_q == LP_WRAP) ? 4'd0 : w_q + 4'd1;
        end
        ready_d = state_d == S_LOAD;
        busy_d  = state_d != S_IDLE;
        done_d  = state_q == S_DONE;
        csn_d   = ~wr;
        addr_d  = wr ? w_q + 4'd1 : addr_q;
        wdat_d  = wr ? wr_data : wdat_q;
        idx_d   = wr ? k_q : idx_q;
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            w_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            csn_q   <= 1'b1;
            addr_q  <= '0;
            wdat_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            w_q     <= w_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            csn_q   <= csn_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            idx_q   <= idx_d;
        end
    end

`ifdef COEFF_SYM_EN
    always_ff @(posedge iClk_12M) begin
        if (state_q == S_LOAD && iCoeffValid && ready_q) coef_buf_q[k_q[4:0]] <= iCoeffData;
    end
`endif

    assign oCoeffReady       = ready_q;
    assign oCoeffiUpdateFlag = busy_q;
    assign oBusy             = busy_q;
    assign oLoadDone         = done_q;
    assign oErr              = err_q;
    assign oCsnRam           = csn_q;
    assign oWrnRam           = csn_q;
    assign oAddrRam          = addr_q;
    assign oWrDtRam          = wdat_q;
    assign oNumOfCoeff       = idx_q;
endmodule

// File: tb/tb_coeff_ram_loader.sv
// tb_coeff_ram_loader: directed bench comparing the loader's RAM write stream against a slot-level model.
module tb_coeff_ram_loader;
    logic        iClk_12M = 1'b0;
    logic        iRst = 1'b1;
    logic        iLoadStart = 1'b0;
    logic [5:0]  iNumTaps = '0;
    logic        iCoeffValid = 1'b0;
    logic [15:0] iCoeffData = '0;
    logic        oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam, oBusy, oLoadDone, oErr;
    logic [3:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [5:0]  oNumOfCoeff;

    int checks = 0, errors = 0, cyc = 0;
    int strobes = 0, busy_n = 0, first_busy = 0, err_n = 0;
    bit mon_en = 1'b0;
    logic [21:0] exp_q [$];
    logic [21:0] mon_e;
    logic [15:0] words [40];
    logic [15:0] seen_dat [64];
    logic [3:0]  seen_addr [64];
    localparam int KH [17] = '{3, 0, -6, -10, -8, 0, 14, 28, 30, 10, -32, -80, -100, -40, 90, 206, 500};
`ifdef COEFF_SYM_EN
    localparam bit SYM = 1'b1;
`else
    localparam bit SYM = 1'b0;
`endif

    coeff_ram_loader #(.P_MAX_COEFF(40), .P_RAM_DEPTH(10), .P_DW(16)) dut (
        .iClk_12M(iClk_12M), .iRst(iRst), .iLoadStart(iLoadStart), .iNumTaps(iNumTaps),
        .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady),
        .oCoeffiUpdateFlag(oCoeffiUpdateFlag), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
        .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam), .oNumOfCoeff(oNumOfCoeff),
        .oBusy(oBusy), .oLoadDone(oLoadDone), .oErr(oErr)
    );

    always #5 iClk_12M = ~iClk_12M;
    always @(posedge iClk_12M) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Every write strobe must match the next expected (slot, data) pair in order.
    always @(negedge iClk_12M) begin
        if (mon_en) begin
            chk("flag_eq_busy", oCoeffiUpdateFlag, oBusy);
            chk("wrn_eq_csn", oWrnRam, oCsnRam);
            if (!oCsnRam) begin
                strobes++;
                seen_dat[oNumOfCoeff] = oWrDtRam;
                seen_addr[oNumOfCoeff] = oAddrRam;
                chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("slot_idx", oNumOfCoeff, mon_e[21:16]);
                    chk("slot_addr", oAddrRam, 32'(int'(mon_e[21:16]) % 10 + 1));
                    chk("slot_data", oWrDtRam, mon_e[15:0]);
                end
            end
            if (oBusy) begin
                busy_n++;
                if (first_busy == 0) first_busy = cyc + 1;
            end
            if (oErr) err_n++;
        end
    end

    task automatic check_reset_vals();
        chk("rst_ready", oCoeffReady, 0);
        chk("rst_flag", oCoeffiUpdateFlag, 0);
        chk("rst_csn", oCsnRam, 1);
        chk("rst_wrn", oWrnRam, 1);
        chk("rst_addr", oAddrRam, 0);
        chk("rst_data", oWrDtRam, 0);
        chk("rst_idx", oNumOfCoeff, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oLoadDone, 0);
        chk("rst_err", oErr, 0);
    endtask

    task automatic load_kaiser();
        for (int k = 0; k < 33; k++) words[k] = 16'(KH[k <= 16 ? k : 32 - k]);
    endtask

    task automatic load_random();
        for (int k = 0; k < 40; k++) words[k] = 16'($urandom);
    endtask

    task automatic run_load(input int n, input bit gaps, input int restart_at, input int abort_at);
        int nw, i, g, t, stalls;
        nw = SYM ? (n + 1) / 2 : n;
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            d = (k >= n) ? 16'd0 : (SYM && k >= nw) ? words[n - 1 - k] : words[k];
            exp_q.push_back({6'(k), d});
        end
        strobes = 0; busy_n = 0; first_busy = 0; stalls = 0; i = 0; g = 0;
        @(negedge iClk_12M);
        iLoadStart = 1'b1;
        iNumTaps = 6'(n);
        t = cyc + 1;
        while (i < nw && g < 1000) begin
            @(negedge iClk_12M);
            g++;
            iLoadStart = (i == restart_at);
            if (i == abort_at) break;
            if (gaps && (g % 3 == 1 || g % 7 == 0)) begin
                iCoeffValid = 1'b0;
                if (oCoeffReady) stalls++;
            end else begin
                iCoeffValid = 1'b1;
                iCoeffData = words[i];
                if (oCoeffReady) i++;
            end
        end
        if (abort_at >= 0 && i == abort_at) begin
            iRst = 1'b1;
            iCoeffValid = 1'b0;
            iLoadStart = 1'b0;
            @(negedge iClk_12M);
            check_reset_vals();
            chk("abort_strobes", strobes, abort_at);
            iRst = 1'b0;
            exp_q.delete();
            return;
        end
        chk("accepted", i, nw);
        @(negedge iClk_12M);
        iCoeffValid = 1'b0;
        iLoadStart = 1'b0;
        chk("ready_drop", oCoeffReady, 0);
        g = 0;
        while (!oLoadDone && g < 200) begin
            @(negedge iClk_12M);
            g++;
        end
        chk("done_seen", oLoadDone, 1);
        chk("done_time", cyc + 1 - t, 42 + stalls);
        chk("busy_at_done", oBusy, 0);
        @(negedge iClk_12M);
        chk("done_width", oLoadDone, 0);
        chk("strobe_count", strobes, 40);
        chk("model_drained", exp_q.size(), 0);
        chk("busy_first", first_busy, t + 1);
        chk("busy_len", busy_n, 41 + stalls);
    endtask

    task automatic bad_start(input int n);
        strobes = 0; busy_n = 0; err_n = 0;
        @(negedge iClk_12M);
        iLoadStart = 1'b1;
        iNumTaps = 6'(n);
        iCoeffValid = 1'b1;
        @(negedge iClk_12M);
        iLoadStart = 1'b0;
        chk("err_pulse", oErr, 1);
        chk("err_busy", oBusy, 0);
        chk("err_ready", oCoeffReady, 0);
        @(negedge iClk_12M);
        chk("err_width", oErr, 0);
        repeat (3) @(negedge iClk_12M);
        iCoeffValid = 1'b0;
        chk("err_count", err_n, 1);
        chk("err_strobes", strobes, 0);
        chk("err_busy_cycles", busy_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge iClk_12M);
        check_reset_vals();
        iRst = 1'b0;
        mon_en = 1'b1;
        load_kaiser();
        run_load(33, 1'b0, -1, -1);
        chk("k16_addr", seen_addr[16], 7);
        chk("k16_data", seen_dat[16], 16'h01F4);
        chk("k17_data", seen_dat[17], 16'h00CE);
        chk("k32_data", seen_dat[32], 16'h0003);
        chk("k0_data", seen_dat[0], 16'h0003);
        chk("k33_zero", seen_dat[33], 0);
        chk("k30_addr", seen_addr[30], 1);
        chk("k39_addr", seen_addr[39], 10);
        load_random();
        run_load(10, 1'b1, -1, -1);
        chk("n10_addr9", seen_addr[9], 10);
        chk("n10_zero10", seen_dat[10], 0);
        bad_start(0);
        bad_start(41);
        load_kaiser();
        run_load(33, 1'b0, -1, 12);
        run_load(33, 1'b0, -1, -1);
        run_load(33, 1'b0, 5, -1);
        load_random();
        run_load(40, 1'b1, -1, -1);
        run_load(1, 1'b0, -1, -1);
        chk("n1_slot1_zero", seen_dat[1], 0);
        repeat (2) @(negedge iClk_12M);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coeff_ram_loader.md
# coeff_ram_loader

Upstream configuration stage for the reconfigurable transposed FIR filter. It accepts a valid/ready stream of signed 16-bit coefficients and drives the filter's coefficient-RAM write port: update flag, chip select, write enable, per-RAM address, write data and global coefficient index. It always writes all 40 RAM slots (4 RAMs × 10 words), zero-filling past the programmed tap count, so stale taps never survive a reload. Runs in the filter's 12 MHz domain.

## Interface
- P_MAX_COEFF, 40, total coefficient slots (4 RAMs × P_RAM_DEPTH)
- P_RAM_DEPTH, 10, words per coefficient RAM
- P_DW, 16, coefficient width (signed)

- iClk_12M  in  1  12 MHz clock
- iRst  in  1  reset, synchronous, active-high
- iLoadStart  in  1  one-cycle request to begin a load; sampled only in IDLE
- iNumTaps  in  6  tap count N, valid range 1..40; sampled with iLoadStart
- iCoeffValid  in  1  coefficient word valid
- iCoeffData  in  16  signed coefficient, tap order 0..N-1
- oCoeffReady  out  1  loader accepts a word this cycle
- oCoeffiUpdateFlag  out  1  high for the whole load window
- oCsnRam  out  1  RAM chip select, active-low, one cycle per write
- oWrnRam  out  1  RAM write enable, active-low, coincident with oCsnRam
- oAddrRam  out  4  per-RAM address = (k mod 10) + 1, range 1..10
- oWrDtRam  out  16  write data
- oNumOfCoeff  out  6  global slot index k (0..39); selects the target RAM
- oBusy  out  1  load in progress
- oLoadDone  out  1  one-cycle pulse at load completion
- oErr  out  1  one-cycle pulse when iNumTaps is rejected

## Operation
- FSM: IDLE, LOAD, MIRROR (only with COEFF_SYM_EN), ZFILL, DONE.
- IDLE: oCoeffReady=0. If iLoadStart=1 and 1≤iNumTaps≤40, latch N, clear k, go to LOAD. If iLoadStart=1 with N=0 or N>40, pulse oErr and stay in IDLE. iCoeffValid is ignored.
- LOAD: oCoeffReady=1. Each handshake (valid & ready) writes slot k with iCoeffData, then increments k. The last accepted word moves the FSM to ZFILL, or to MIRROR in symmetric mode. Gaps in valid only stall the load.
- ZFILL: writes 0 to slots k..39, one per cycle, then goes to DONE. Skipped if N=40.
- DONE: oLoadDone=1 for one cycle, then IDLE.
- Write strobe: all write outputs are registered. oCsnRam=oWrnRam=0 for exactly one cycle per slot. Otherwise oCsnRam=oWrnRam=1, and oAddrRam/oWrDtRam/oNumOfCoeff hold their last value.
- oBusy and oCoeffiUpdateFlag are high from the cycle after the accepted iLoadStart through the final zero-fill write. They drop in the same cycle oLoadDone rises.
- iLoadStart while busy is ignored.
- oAddrRam wraps 10→1 at k=10, 20, 30.
- Data is passed through unmodified; no saturation.

## Timing
- Reset values: oCoeffReady=0, oCoeffiUpdateFlag=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oNumOfCoeff=0, oBusy=0, oLoadDone=0, oErr=0. FSM=IDLE, k=0.
- iLoadStart sampled at edge t: oBusy, oCoeffiUpdateFlag and oCoeffReady are high at t+1.
- A word accepted at edge c produces its write strobe at c+1.
- Back-to-back stream, N=33: accepts at t+1..t+33, data writes at t+2..t+34, zero fill of slots 33..39 at t+35..t+41, oLoadDone at t+42.
- Maximum throughput is one slot write per cycle. Total load time is 40 writes plus stream stalls.
- iRst mid-load: the next edge returns all outputs to their reset values and the FSM to IDLE. Partially written RAM contents are undefined; the filter must be reloaded.
- oErr fires at t+1 after the rejected request.

## Configuration
- COEFF_SYM_EN defined:
  - LOAD accepts only H=ceil(N/2) words and writes them to slots 0..H-1.
  - The same words are stored in an internal 20×16 buffer.
  - MIRROR then writes slots H..N-1, one per cycle, with data = buf[N-1-k]. For odd N the centre tap is not duplicated.
  - For N=1, H=1 and MIRROR is empty.
- COEFF_SYM_EN undefined: no buffer and no MIRROR state; LOAD accepts all N words.
- The filter-side write sequence is identical in both modes for a symmetric coefficient set.

## Test plan
- Reset, then iLoadStart with N=33 and 33 contiguous Kaiser taps (0x0003, 0x0000, -0x0006, …, 0x01F4 at tap 16, …, 0x0003) → 40 strobes. Slot 16 is written at oAddrRam=7 with 0x01F4; slots 33..39 are written with 0. oLoadDone at t+42; oCoeffiUpdateFlag high t+1..t+41.
- N=10 with random valid gaps → slots 0..9 hold the stream; 30 zero writes follow. Exactly 40 strobes total, each one cycle wide, with oAddrRam cycling 1..10 four times.
- iNumTaps=0 and iNumTaps=41 → oErr pulses once each; no strobes; oBusy stays 0.
- iRst asserted after 12 accepted words → all outputs return to reset values on the next edge. A fresh load with N=33 then completes normally.
- iLoadStart re-asserted mid-load → ignored; strobe count and oLoadDone timing unchanged.
- COEFF_SYM_EN, N=33, 17 words streamed → oCoeffReady drops after 17 handshakes. Slot 17 is written with 0x00CE and slot 32 with 0x0003; oLoadDone at t+42.
